mac_accum_ctrl: RTL and testbench

Sequential controller that drives the parallel MAC array and collects its results. It accepts a stream of activation/weight vector beats over a valid/ready handshake and feeds each beat, together with registered per-lane accumulators, into the array inputs. It captures the array output back into the accumulators, then presents the finished COUNT-lane dot-product vector on a valid/ready result port. It sits between the layer sequencer/buffers and the combinational MAC array.

---
 rtl/mac_accum_ctrl.sv | 143 ++++++++++++++
 tb/tb_mac_accum_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_ctrl.sv
// -----------------------------------------------------------------------------
// mac_accum_ctrl
//
// Sequencing controller for a combinational COUNT-lane MAC array.  A run is
// started with a beat count; each accepted activation/weight beat is passed to
// the array together with the per-lane accumulators, and the array result
// (a*w + y) is captured back into the accumulators.  After the last beat the
// finished vector is offered on a valid/ready result port.
//
// Ports
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   start, vec_len        run request and beat count (sampled only when idle)
//   busy                  high whenever a run is in progress or being drained
//   in_valid, in_ready    beat handshake
//   a_in, w_in            activation / weight beats, lane i at [i*DW +: DW]
//   mac_a, mac_w, mac_y   array operands (accumulators on mac_y)
//   mac_res               array output, lane i at [i*2DW +: 2DW]
//   res_valid, res_ready  result handshake
//   res_data              accumulated result vector
// -----------------------------------------------------------------------------
module mac_accum_ctrl #(
    parameter int COUNT      = 128,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [LEN_WIDTH-1:0]              vec_len,
    output logic                              busy,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH*COUNT-1:0]       a_in,
    input  logic [DATA_WIDTH*COUNT-1:0]       w_in,
    output logic [DATA_WIDTH*COUNT-1:0]       mac_a,
    output logic [DATA_WIDTH*COUNT-1:0]       mac_w,
    output logic [2*DATA_WIDTH*COUNT-1:0]     mac_y,
    input  logic [2*DATA_WIDTH*COUNT-1:0]     mac_res,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [2*DATA_WIDTH*COUNT-1:0]     res_data
);

    localparam int ACC_BITS = 2 * DATA_WIDTH * COUNT;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_BITS-1:0]    acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic                   beat_fire_s;
    logic                   last_beat_s;

    // A beat is consumed whenever the controller is accumulating and the source is valid.
    assign beat_fire_s = (state_q == S_ACCUM) && in_valid;
    // len_q is never zero in ACCUM, so len_q-1 cannot underflow; the counter
    // tops out at len_q and therefore never wraps even for the maximum length.
    assign last_beat_s = (cnt_q == (len_q - LEN_ONE));

    // State, accumulator, beat counter and latched length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= LEN_ZERO;
            len_q   <= LEN_ZERO;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                // A zero-length request is dropped without touching any state.
                if (start && (vec_len != LEN_ZERO)) begin
                    state_d = S_ACCUM;
                    len_d   = vec_len;
                    cnt_d   = LEN_ZERO;
                    acc_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (beat_fire_s) begin
                    // The array result is stored verbatim: lanes wrap, never saturate.
                    acc_d = mac_res;
                    cnt_d = cnt_q + LEN_ONE;
                    if (last_beat_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the registered state and accumulators.
    always_comb begin
        busy      = (state_q != S_IDLE);
        in_ready  = (state_q == S_ACCUM);
        res_valid = (state_q == S_DONE);
        mac_y     = acc_q;
        res_data  = acc_q;
        if (state_q == S_ACCUM) begin
            mac_a = a_in;
            mac_w = w_in;
        end else begin
            mac_a = '0;
            mac_w = '0;
        end
    end

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mac_accum_ctrl
//
// Bench for mac_accum_ctrl with four 16-bit lanes.  A signed MAC array is
// modelled next to the DUT; expected dot products come from a per-run
// reference that simply sums signed lane products modulo 2^32.
// -----------------------------------------------------------------------------
module tb_mac_accum_ctrl;

    localparam int COUNT = 4;
    localparam int DW    = 16;
    localparam int LW    = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [LW-1:0]         vec_len;
    logic                  busy;
    logic                  in_valid;
    logic                  in_ready;
    logic [DW*COUNT-1:0]   a_in;
    logic [DW*COUNT-1:0]   w_in;
    logic [DW*COUNT-1:0]   mac_a;
    logic [DW*COUNT-1:0]   mac_w;
    logic [2*DW*COUNT-1:0] mac_y;
    logic [2*DW*COUNT-1:0] mac_res;
    logic                  res_valid;
    logic                  res_ready;
    logic [2*DW*COUNT-1:0] res_data;

    int checks = 0;
    int errors = 0;

    logic [DW*COUNT-1:0] beat_a [0:255];
    logic [DW*COUNT-1:0] beat_w [0:255];

    typedef struct {
        int                  len;
        logic [DW*COUNT-1:0] a0, w0, a1, w1, a2, w2;
        logic [127:0]        exp;
        int                  gmin, gmax, hold;
        bit                  pulse;
    } vec_t;

    vec_t vecs [0:4];

    mac_accum_ctrl #(
        .COUNT      (COUNT),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vec_len   (vec_len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .w_in      (w_in),
        .mac_a     (mac_a),
        .mac_w     (mac_w),
        .mac_y     (mac_y),
        .mac_res   (mac_res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    // Signed MAC array: low 32 bits of the sign-extended product plus y.
    always_comb begin
        mac_res = '0;
        for (int i = 0; i < COUNT; i++) begin
            mac_res[i*32 +: 32] = mac_y[i*32 +: 32]
                + 32'({{16{mac_a[i*16+15]}}, mac_a[i*16 +: 16]}
                    * {{16{mac_w[i*16+15]}}, mac_w[i*16 +: 16]});
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_prod(input logic [15:0] a, input logic [15:0] w);
        int sa;
        int sw;
        sa = $signed(a);
        sw = $signed(w);
        return 32'(sa * sw);
    endfunction

    // One complete run using beat_a/beat_w[0..len-1]; got is res_data on the first DONE cycle.
    task automatic do_run(input int len, input int gmin, input int gmax, input int hold,
                          input bit pulse, output logic [127:0] got);
        logic [127:0] model;
        int gap;
        model = '0;
        @(negedge clk);
        start   = 1'b1;
        vec_len = LW'(len);
        @(negedge clk);
        start   = 1'b0;
        vec_len = LW'($urandom);
        check("run_start", {157'd0, busy, in_ready, res_valid}, {157'd0, 3'b110});
        for (int b = 0; b < len; b++) begin
            gap = $urandom_range(gmax, gmin);
            for (int g = 0; g < gap; g++) begin
                if (pulse) begin
                    start   = 1'b1;
                    vec_len = 8'd5;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                start = 1'b0;
                check("gap_hold", {32'd0, mac_y}, {32'd0, model});
            end
            in_valid = 1'b1;
            a_in     = beat_a[b];
            w_in     = beat_w[b];
            #1;
            check("pass_aw", {32'd0, mac_a, mac_w}, {32'd0, beat_a[b], beat_w[b]});
            check("acc_in", {31'd0, in_ready, mac_y}, {31'd0, 1'b1, model});
            for (int l = 0; l < COUNT; l++) begin
                model[l*32 +: 32] = model[l*32 +: 32]
                    + lane_prod(beat_a[b][l*16 +: 16], beat_w[b][l*16 +: 16]);
            end
            @(negedge clk);
            in_valid = 1'b0;
            a_in     = {$urandom, $urandom};
            w_in     = {$urandom, $urandom};
        end
        got = res_data;
        check("done_flags", {157'd0, busy, in_ready, res_valid}, {157'd0, 3'b101});
        check("done_data", {32'd0, res_data}, {32'd0, model});
        check("done_gate", {32'd0, mac_a, mac_w}, 160'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("done_stable", {30'd0, res_valid, in_ready, res_data}, {30'd0, 1'b1, 1'b0, model});
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("to_idle", {158'd0, busy, res_valid}, 160'd0);
        check("acc_retain", {32'd0, mac_y}, {32'd0, model});
    endtask

    logic [127:0] got;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        vec_len   = '0;
        in_valid  = 1'b0;
        a_in      = '0;
        w_in      = '0;
        res_ready = 1'b0;

        vecs[0] = '{len:3, a0:64'h2, w0:64'h3, a1:64'h4, w1:64'h5, a2:64'hFFFF, w2:64'h7,
                    exp:128'h13, gmin:0, gmax:0, hold:0, pulse:1'b0};
        vecs[1] = '{len:3, a0:64'h2, w0:64'h3, a1:64'h4, w1:64'h5, a2:64'hFFFF, w2:64'h7,
                    exp:128'h13, gmin:2, gmax:2, hold:5, pulse:1'b1};
        vecs[2] = '{len:3, a0:64'h7FFF, w0:64'h7FFF, a1:64'h7FFF, w1:64'h7FFF, a2:64'h7FFF,
                    w2:64'h7FFF, exp:128'hBFFD0003, gmin:0, gmax:1, hold:1, pulse:1'b0};
        vecs[3] = '{len:1, a0:64'h0000_0000_FFFE_0006, w0:64'h0000_0000_0003_0007, a1:64'h0,
                    w1:64'h0, a2:64'h0, w2:64'h0,
                    exp:128'h00000000_00000000_FFFFFFFA_0000002A, gmin:0, gmax:0, hold:2, pulse:1'b0};
        vecs[4] = '{len:2, a0:64'h8000_8000_0000_0000, w0:64'h7FFF_8000_0000_0000,
                    a1:64'h8000_8000_0000_0000, w1:64'h7FFF_8000_0000_0000, a2:64'h0, w2:64'h0,
                    exp:128'h80010000_80000000_00000000_00000000, gmin:0, gmax:0, hold:0, pulse:1'b0};

        #1;
        check("reset_flags", {157'd0, busy, in_ready, res_valid}, 160'd0);
        check("reset_data", {32'd0, res_data}, 160'd0);
        check("reset_mac", {mac_a, mac_w, 32'd0}, 160'd0);
        check("reset_y", {32'd0, mac_y}, 160'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int v = 0; v < 5; v++) begin
            beat_a[0] = vecs[v].a0; beat_w[0] = vecs[v].w0;
            beat_a[1] = vecs[v].a1; beat_w[1] = vecs[v].w1;
            beat_a[2] = vecs[v].a2; beat_w[2] = vecs[v].w2;
            do_run(vecs[v].len, vecs[v].gmin, vecs[v].gmax, vecs[v].hold, vecs[v].pulse, got);
            check("table_result", {32'd0, got}, {32'd0, vecs[v].exp});
        end

        // Zero-length start is ignored.
        @(negedge clk);
        start   = 1'b1;
        vec_len = 8'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("zero_len", {157'd0, busy, in_ready, res_valid}, 160'd0);
        end
        start = 1'b0;

        // Reset in the middle of a run, after two of three beats.
        @(negedge clk);
        start   = 1'b1;
        vec_len = 8'd3;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        a_in     = 64'h5;
        w_in     = 64'h9;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_flags", {157'd0, busy, in_ready, res_valid}, 160'd0);
        check("midrst_data", {32'd0, res_data}, 160'd0);
        check("midrst_mac", {mac_a, mac_w, 32'd0}, 160'd0);
        check("midrst_y", {32'd0, mac_y}, 160'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {157'd0, busy, in_ready, res_valid}, 160'd0);
        beat_a[0] = 64'h6;
        beat_w[0] = 64'h7;
        do_run(1, 0, 0, 0, 1'b0, got);
        check("post_rst_run", {128'd0, got[31:0]}, 160'd42);

        // Randomised runs against the reference sums.
        for (int r = 0; r < 20; r++) begin
            int len;
            len = $urandom_range(8, 1);
            for (int b = 0; b < len; b++) begin
                beat_a[b] = {$urandom, $urandom};
                beat_w[b] = {$urandom, $urandom};
            end
            do_run(len, 0, 2, $urandom_range(3, 0), 1'($urandom), got);
        end

        // Maximum length: the beat counter must not wrap early.
        for (int b = 0; b < 255; b++) begin
            beat_a[b] = {$urandom, $urandom};
            beat_w[b] = {$urandom, $urandom};
        end
        do_run(255, 0, 0, 1, 1'b0, got);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
